// File: rtl/ines_loader.sv
// iNES ROM loader: captures the 16-byte header from the download stream and
// packs the following file bytes into 16-bit words written out through a small FIFO.
module ines_loader #(
    parameter logic [7:0] MATCH_INDEX = 8'h00,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic        mem_ack,
    output logic [7:0]  mapper,
    output logic [7:0]  prg_size,
    output logic [7:0]  chr_size,
    output logic        mirroring,
    output logic        battery,
    output logic        hdr_valid,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        FLUSH,
        DONE
    } state_t;

    state_t       state_reg, state_next;
    logic         dl_reg;
    logic         dl_rise, dl_fall, idx_match, wr_ok, start, hdr_we, data_we;
    logic [22:0]  off;

    logic [7:0]   hdr_reg [16];
    logic         hdr_valid_reg;
    logic         overflow_reg;

    logic         pend_reg;
    logic [7:0]   low_reg;
    logic [21:0]  paddr_reg;

    logic         push, pop, push_ok, fifo_empty, fifo_full;
    logic [37:0]  push_entry;
    logic [PW:0]  wr_ptr_reg, rd_ptr_reg;
    logic [37:0]  fifo_mem [FIFO_DEPTH];

    logic         mem_req_reg;
    logic [21:0]  mem_addr_reg;
    logic [15:0]  mem_din_reg;

    assign idx_match = (ioctl_index == MATCH_INDEX);
    assign dl_rise   = ioctl_download & ~dl_reg;
    assign dl_fall   = ~ioctl_download & dl_reg;
    assign wr_ok     = ioctl_wr & idx_match;
    assign start     = ((state_reg == IDLE) || (state_reg == DONE)) && dl_rise && idx_match;
    assign hdr_we    = wr_ok && (state_reg == HEADER) && (ioctl_addr < 25'd16);
    assign data_we   = wr_ok && (state_reg == DATA);
    // Only the low 23 bits of the data offset feed the word address and parity.
    assign off       = ioctl_addr[22:0] - 23'd16;

    // dl_reg resets high so a download still active across reset is not seen as a new start.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_reg    <= 1'b1;
            state_reg <= IDLE;
        end else begin
            dl_reg    <= ioctl_download;
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) state_next = HEADER;
            end
            HEADER: begin
                if (dl_fall)
                    state_next = FLUSH;
                else if (wr_ok && (ioctl_addr == 25'd15))
                    state_next = DATA;
            end
            DATA: begin
                if (dl_fall) state_next = FLUSH;
            end
            FLUSH: begin
                if (fifo_empty && !mem_req_reg && !pend_reg) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) hdr_reg[i] <= 8'h00;
            hdr_valid_reg <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < 16; i++) hdr_reg[i] <= 8'h00;
            hdr_valid_reg <= 1'b0;
        end else if (hdr_we) begin
            for (int i = 0; i < 16; i++) begin
                if (ioctl_addr[3:0] == 4'(i)) hdr_reg[i] <= ioctl_dout;
            end
            if (ioctl_addr[3:0] == 4'd3)
                hdr_valid_reg <= (hdr_reg[0] == 8'h4E) && (hdr_reg[1] == 8'h45) &&
                                 (hdr_reg[2] == 8'h53) && (ioctl_dout == 8'h1A);
        end
    end

    // Byte pairing: even offsets wait for their odd partner; FLUSH drains a lone low byte.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (data_we && off[0]) begin
            push       = 1'b1;
            push_entry = {off[22:1], ioctl_dout, (pend_reg ? low_reg : 8'h00)};
        end else if ((state_reg == FLUSH) && pend_reg) begin
            push       = 1'b1;
            push_entry = {paddr_reg, 8'h00, low_reg};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg  <= 1'b0;
            low_reg   <= 8'h00;
            paddr_reg <= '0;
        end else if (start) begin
            pend_reg  <= 1'b0;
        end else if (data_we) begin
            if (!off[0]) begin
                pend_reg  <= 1'b1;
                low_reg   <= ioctl_dout;
                paddr_reg <= off[22:1];
            end else begin
                pend_reg  <= 1'b0;
            end
        end else if ((state_reg == FLUSH) && pend_reg) begin
            pend_reg <= 1'b0;
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == (PW + 1)'(FIFO_DEPTH));
    assign pop        = !mem_req_reg && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_mem[wr_ptr_reg[PW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (start)
                overflow_reg <= 1'b0;
            else if (push && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    // One request in flight: the head is popped into the output register only while idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
        end else if (pop) begin
            mem_req_reg                 <= 1'b1;
            {mem_addr_reg, mem_din_reg} <= fifo_mem[rd_ptr_reg[PW-1:0]];
        end else if (mem_req_reg && mem_ack) begin
            mem_req_reg <= 1'b0;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;
    assign mapper    = {hdr_reg[7][7:4], hdr_reg[6][7:4]};
    assign prg_size  = hdr_reg[4];
    assign chr_size  = hdr_reg[5];
    assign mirroring = hdr_reg[6][0];
    assign battery   = hdr_reg[6][1];
    assign hdr_valid = hdr_valid_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg == HEADER) || (state_reg == DATA) || (state_reg == FLUSH);
    assign done      = (state_reg == DONE);

endmodule
